// File: rtl/vpu_seq.sv
// Issue-side sequencer for the VPU ALU op unit: accepts one vector command, streams
// operand pairs into the op unit and returns results on a one-entry valid/ready stream.
module vpu_seq #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_const,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              op_start,
  output logic [DATA_W-1:0] op_operand0,
  output logic [DATA_W-1:0] op_operand1,
  output logic [OP_W-1:0]   op_opcode,
  input  logic [DATA_W-1:0] op_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [OP_W-1:0] OPC_MULT_CONST = OP_W'(2);

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0] const_q, const_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic issue_last;
  logic out_fire;

  // Handshake outputs are gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    cmd_ready   = rst_n && (state_q == S_IDLE);
    in_ready    = rst_n && (state_q == S_RUN) && (!out_valid_q || out_ready);
    op_start    = in_valid && in_ready;
    busy        = rst_n && (state_q != S_IDLE);
    issue_last  = (cnt_q == (len_q - LEN_W'(1)));
    out_fire    = out_valid_q && out_ready;
    op_opcode   = opcode_q;
    op_operand0 = op_start ? in_a : '0;
    op_operand1 = '0;
    if (op_start) begin
      op_operand1 = (opcode_q == OPC_MULT_CONST) ? const_q : in_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    opcode_d    = opcode_q;
    const_d     = const_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          opcode_d = cmd_opcode;
          len_d    = cmd_len;
          const_d  = cmd_const;
          cnt_d    = '0;
          if (cmd_len != '0) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // A refill on the same edge as a drain overrides the clear above.
        if (op_start) begin
          out_data_d  = op_result;
          out_valid_d = 1'b1;
          out_last_d  = issue_last;
          cnt_d       = cnt_q + LEN_W'(1);
          if (issue_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      opcode_q    <= '0;
      const_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      opcode_q    <= opcode_d;
      const_q     <= const_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_vpu_seq.sv
// Directed bench for vpu_seq: a small op-unit model drives op_result, vectors come
// from a table, and backpressure / zero-length / mid-command reset are hand sequences.
module tb_vpu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [7:0]  cmd_len;
  logic [31:0] cmd_const;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        op_start;
  logic [31:0] op_operand0;
  logic [31:0] op_operand1;
  logic [3:0]  op_opcode;
  logic [31:0] op_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vpu_seq #(.DATA_W(32), .OP_W(4), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_len(cmd_len), .cmd_const(cmd_const),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_start(op_start), .op_operand0(op_operand0), .op_operand1(op_operand1),
    .op_opcode(op_opcode), .op_result(op_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  // Combinational op unit: modulo-2^32 arithmetic, undefined opcodes return 0.
  always_comb begin
    case (op_opcode)
      4'd0:    op_result = op_operand0 + op_operand1;
      4'd1:    op_result = op_operand0 - op_operand1;
      4'd2:    op_result = op_operand0 * op_operand1;
      default: op_result = 32'd0;
    endcase
  end

  typedef struct {
    string           name;
    logic [3:0]      opcode;
    int              len;
    logic [31:0]     k;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input int len, input logic [31:0] k);
    chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_len    = len[7:0];
    cmd_const  = k;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // Streams one command with out_ready held high; called at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v);
    int idx;
    int got;
    int guard;
    idx = 0;
    got = 0;
    guard = 0;
    out_ready = 1'b1;
    send_cmd(v.opcode, v.len, v.k);
    while (got < v.len && guard < 40) begin
      if (out_valid) begin
        $display("%s result %0d: data=0x%08h last=%0b", v.name, got, out_data, out_last);
        chk({v.name, "_data"}, out_data, v.exp[got]);
        chk({v.name, "_last"}, {31'd0, out_last}, (got == v.len - 1) ? 32'd1 : 32'd0);
        got++;
      end
      if (idx < v.len) begin
        in_valid = 1'b1;
        in_a     = v.a[idx];
        in_b     = v.b[idx];
        #1;
        if (in_ready) begin
          chk({v.name, "_op_start"}, {31'd0, op_start}, 32'd1);
          chk({v.name, "_op_opcode"}, {28'd0, op_opcode}, {28'd0, v.opcode});
          chk({v.name, "_op_operand1"}, op_operand1, (v.opcode == 4'd2) ? v.k : v.b[idx]);
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (got < v.len) begin
      failures++;
      $display("FAIL %s_timeout: got %0d results expected %0d", v.name, got, v.len);
    end
    chk({v.name, "_cycles"}, guard, v.len + 1);
    chk({v.name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({v.name, "_idle_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({v.name, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t r1;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_len = '0; cmd_const = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    vecs[0] = '{name: "add4", opcode: 4'd0, len: 4, k: 32'd0,
                a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd40, 32'd30, 32'd20, 32'd10},
                exp: {32'd44, 32'd33, 32'd22, 32'd11}};
    vecs[1] = '{name: "sub2", opcode: 4'd1, len: 2, k: 32'd0,
                a: {32'd0, 32'd0, 32'd5, 32'd0}, b: {32'd0, 32'd0, 32'd5, 32'd1},
                exp: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}};
    vecs[2] = '{name: "mulc3", opcode: 4'd2, len: 3, k: 32'd3,
                a: {32'd0, 32'h5555_5556, 32'd7, 32'd2},
                b: {32'd0, $urandom, $urandom, $urandom},
                exp: {32'd0, 32'h0000_0002, 32'd21, 32'd6}};
    vecs[3] = '{name: "undef1", opcode: 4'd9, len: 1, k: 32'd0,
                a: {32'd0, 32'd0, 32'd0, 32'd8}, b: {32'd0, 32'd0, 32'd0, 32'd9},
                exp: {32'd0, 32'd0, 32'd0, 32'd0}};

    // Reset behaviour
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: ADD len=3, out_ready low for 3 cycles after the first result
    out_ready = 1'b1;
    send_cmd(4'd0, 3, 32'd0);
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd100;
    @(negedge clk);
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_first_data", out_data, 32'd101);
    out_ready = 1'b0;
    in_a = 32'd2; in_b = 32'd200;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_stall_op_start", {31'd0, op_start}, 32'd0);
      chk("bp_stall_operand0", op_operand0, 32'd0);
      chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_stall_data", out_data, 32'd101);
      chk("bp_stall_last", {31'd0, out_last}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_refill_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_hold_data", out_data, 32'd101);
    @(negedge clk);
    $display("bp result 1: data=0x%08h last=%0b", out_data, out_last);
    chk("bp_second_data", out_data, 32'd202);
    chk("bp_second_last", {31'd0, out_last}, 32'd0);
    in_a = 32'd3; in_b = 32'd300;
    @(negedge clk);
    in_valid = 1'b0;
    $display("bp result 2: data=0x%08h last=%0b", out_data, out_last);
    chk("bp_third_data", out_data, 32'd303);
    chk("bp_third_last", {31'd0, out_last}, 32'd1);
    chk("bp_drain_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_drain_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_done_busy", {31'd0, busy}, 32'd0);

    // Zero-length command is accepted and produces nothing
    send_cmd(4'd0, 0, 32'd0);
    $display("len0 command accepted");
    for (int c = 0; c < 3; c++) begin
      chk("len0_busy", {31'd0, busy}, 32'd0);
      chk("len0_out_valid", {31'd0, out_valid}, 32'd0);
      chk("len0_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
    end

    // Reset after 2 of 5 elements issued
    send_cmd(4'd0, 5, 32'd0);
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1;
    @(negedge clk);
    in_a = 32'd2; in_b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_pending_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("abort: reset pulse applied mid-command");
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_last", {31'd0, out_last}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    r1 = '{name: "post_abort", opcode: 4'd0, len: 1, k: 32'd0,
           a: {32'd0, 32'd0, 32'd0, 32'd1}, b: {32'd0, 32'd0, 32'd0, 32'd1},
           exp: {32'd0, 32'd0, 32'd0, 32'd2}};
    run_vec(r1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
